// File: rtl/bfloat16_packer_pkg.sv
// Shared types and constants for the bfloat16 packer slice.
package bf16_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_OUT
  } state_t;

  localparam int BF16_BIAS    = 127;
  localparam int BF16_EXP_MAX = 255;

  // Bit positions inside the 4-bit flag word {overflow, underflow, inexact, zero}
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW  = 3;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

endpackage

// File: rtl/bfloat16_packer_if.sv
// Operand/result handshake bundle for the bfloat16 packer.
interface bfloat16_packer_if;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exponent;
  logic [15:0]       in_mantissa;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_result;
  logic [3:0]        out_flags;

  // Producer/consumer side
  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // Packer side
  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/bfloat16_packer_round.sv
// Round-to-nearest-even of a normalised 15-bit significand into bfloat16.
module bf16_round_rne
  import bf16_pkg::*;
(
  input  logic              i_sign,
  input  logic [14:0]       i_mant,
  input  logic signed [9:0] i_exp,
  input  logic              i_sticky,
  output bf16_t             o_result,
  output logic [3:0]        o_flags
);

  logic              w_lsb;
  logic              w_guard;
  logic              w_sticky_all;
  logic              w_up;
  logic [8:0]        w_sum;
  logic              w_normal;
  logic signed [10:0] w_exp_adj;
  logic              w_ovf;

  // Rounding, encoding and flag generation
  always_comb begin
    w_lsb        = i_mant[7];
    w_guard      = i_mant[6];
    w_sticky_all = i_sticky | (|i_mant[5:0]);
    w_up         = w_guard & (w_sticky_all | w_lsb);
    w_sum        = {1'b0, i_mant[14:7]} + {8'h00, w_up};
    // A carry out of the hidden bit means the significand became 1.0 at exp+1
    w_normal     = w_sum[8] | w_sum[7];
    w_exp_adj    = {i_exp[9], i_exp} + {10'h000, w_sum[8]};
    w_ovf        = w_normal && (int'(w_exp_adj) >= BF16_EXP_MAX);

    o_result      = '0;
    o_flags       = '0;
    o_result.sign = i_sign;
    if (w_ovf) begin
      o_result.exp           = 8'hFF;
      o_result.frac          = 7'h00;
      o_flags[FLAG_OVERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      // Subnormal rounding up into the hidden bit lands on field 1 because exp is 1 there
      o_result.exp            = w_normal ? w_exp_adj[7:0] : 8'h00;
      o_result.frac           = w_sum[8] ? 7'h00 : w_sum[6:0];
      o_flags[FLAG_INEXACT]   = w_guard | w_sticky_all;
      o_flags[FLAG_UNDERFLOW] = (w_guard | w_sticky_all) & ~w_normal;
      o_flags[FLAG_ZERO]      = ~w_normal & (w_sum[6:0] == 7'h00);
    end
  end

endmodule

// File: rtl/bfloat16_packer.sv
// Normalises a wide signed-exponent magnitude and packs it as bfloat16.
module bfloat16_packer
  import bf16_pkg::*;
#(
  parameter int RSHIFT_CAP = 24
) (
  input  logic               clock,
  input  logic               n_reset,
  bfloat16_packer_if.slave   bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [15:0]       r_mant;
  logic              r_sticky;
  logic [15:0]       r_result;
  logic [3:0]        r_flags;

  logic              w_in_zero;
  logic              w_in_tiny;
  logic              w_rshift;
  logic              w_lshift;
  logic signed [9:0] w_exp_inc;
  bf16_t             w_round_result;
  logic [3:0]        w_round_flags;

  bf16_round_rne u_round (
    .i_sign   (r_sign),
    .i_mant   (r_mant[14:0]),
    .i_exp    (r_exp),
    .i_sticky (r_sticky),
    .o_result (w_round_result),
    .o_flags  (w_round_flags)
  );

  // Operand classification and single-step normalisation decisions
  always_comb begin
    w_in_zero = (bus.in_mantissa == '0);
    w_in_tiny = int'(bus.in_exponent) < (1 - RSHIFT_CAP);
    w_rshift  = r_mant[15] || ((r_exp < 10'sd1) && (r_mant != '0));
    w_lshift  = !w_rshift && !r_mant[14] && (r_exp > 10'sd1);
    // Saturate rather than wrap at the top of the signed range
    w_exp_inc = (r_exp == 10'sd511) ? r_exp : r_exp + 10'sd1;
  end

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next_state = w_in_zero ? S_OUT : S_NORM;
      S_NORM:  if (!w_rshift && !w_lshift) w_next_state = S_ROUND;
      S_ROUND: w_next_state = S_OUT;
      S_OUT:   if (bus.out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    bus.in_ready   = (r_state == S_IDLE);
    bus.out_valid  = (r_state == S_OUT);
    bus.out_result = r_result;
    bus.out_flags  = r_flags;
  end

  // Datapath: capture, normalise, latch rounded result
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_sticky <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sign <= bus.in_sign;
            if (w_in_zero) begin
              r_result <= {bus.in_sign, 15'h0000};
              r_flags  <= 4'(1 << FLAG_ZERO);
            end else if (w_in_tiny) begin
              r_mant   <= '0;
              r_sticky <= |bus.in_mantissa;
              r_exp    <= 10'sd1;
            end else begin
              r_mant   <= bus.in_mantissa;
              r_exp    <= bus.in_exponent;
              r_sticky <= 1'b0;
            end
          end
        end
        S_NORM: begin
          if (w_rshift) begin
            r_mant   <= {1'b0, r_mant[15:1]};
            r_sticky <= r_sticky | r_mant[0];
            r_exp    <= w_exp_inc;
          end else if (w_lshift) begin
            r_mant <= {r_mant[14:0], 1'b0};
            r_exp  <= r_exp - 10'sd1;
          end
        end
        S_ROUND: begin
          r_result <= w_round_result;
          r_flags  <= w_round_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat16_packer.sv
// Scoreboard bench for bfloat16_packer with an arithmetic reference model.
module tb_bfloat16_packer;

  localparam int CAP = 24;

  logic clock = 1'b0;
  logic n_reset;
  always #5 clock = ~clock;

  bfloat16_packer_if bus ();

  bfloat16_packer #(.RSHIFT_CAP(CAP)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic bp_mode = 1'b0;
  logic bp_val = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Exact value m * 2^(e-141) rounded to the nearest bfloat16 (ties to even).
  function automatic void model(input logic s, input int e, input logic [15:0] m,
                                output logic [15:0] res, output logic [3:0] flg,
                                output int lat);
    int p, q, f, r, need, l;
    longint k, rem, half, one;
    logic inx;
    one = 1;
    if (m == 16'h0) begin
      res = {s, 15'h0}; flg = 4'b0001; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 16; i++) if (m[i]) p = i;
    // shifts needed to bring the leading one to the hidden position within exponent limits
    if (e < 1 - CAP) lat = 3;
    else begin
      r = (p == 15) ? 1 : 0;
      need = (e < 1) ? 1 - e : 0;
      if (need > p + 1) need = p + 1;
      if (need > r) r = need;
      l = 0;
      if (r == 0 && p < 14 && e > 1) l = (14 - p < e - 1) ? 14 - p : e - 1;
      lat = 3 + r + l;
    end
    // q = weight index of the kept lsb: normal keeps 8 bits, subnormal quantum is 2^-133
    q = (p - 7 > 8 - e) ? p - 7 : 8 - e;
    if (q <= 0) begin
      k = longint'(m) << (-q); inx = 1'b0;
    end else if (q >= 17) begin
      k = 0; inx = 1'b1;
    end else begin
      k = longint'(m) >> q;
      rem = longint'(m) & ((one << q) - 1);
      half = one << (q - 1);
      inx = (rem != 0);
      if (rem > half || (rem == half && k[0])) k++;
    end
    if (k == 256) begin k = 128; q++; end
    if (k >= 128) begin
      f = q + e - 7;
      if (f >= 255) begin
        res = {s, 8'hFF, 7'h0}; flg = 4'b1010;
      end else begin
        res = {s, 8'(f), 7'(k)}; flg = {2'b00, inx, 1'b0};
      end
    end else begin
      res = {s, 8'h00, 7'(k)};
      flg = {1'b0, inx, inx, (k == 0)};
    end
  endfunction

  task automatic drive(input logic s, input int e, input logic [15:0] m, input logic pushit,
                       input logic use_model, input logic [15:0] cres, input logic [3:0] cflg,
                       input int clat);
    exp_t x;
    logic ok;
    @(negedge clock);
    bus.in_sign = s;
    bus.in_exponent = 10'(e);
    bus.in_mantissa = m;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    if (use_model) model(s, e, m, x.res, x.flg, x.lat);
    else begin x.res = cres; x.flg = cflg; x.lat = clat; end
    x.acc = cyc + 1;
    if (pushit) sb.push_back(x);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000; t++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      @(negedge clock);
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
  endtask

  // Consumer ready: random or forced
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1 bus.out_ready = bp_mode ? bp_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  always @(negedge clock) begin
    if (!n_reset) prev_valid <= 1'b0;
    else begin
      if (bus.out_valid) begin
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: result %0h with empty scoreboard, expected none", bus.out_result);
        end else begin
          if (!prev_valid) check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
          check("result", 32'(bus.out_result), 32'(sb[0].res));
          check("flags", 32'(bus.out_flags), 32'(sb[0].flg));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      prev_valid <= bus.out_valid;
    end
  end

  initial begin
    logic [15:0] r0;
    logic [15:0] m;
    int e, ce, cm;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exponent = '0;
    bus.in_mantissa = '0;
    n_reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    n_reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed corners with hand-derived expectations
    drive(1'b0, 127, 16'h4000, 1'b1, 1'b0, 16'h3F80, 4'b0000, 3);
    drive(1'b0, 127, 16'h8000, 1'b1, 1'b0, 16'h4000, 4'b0000, 4);
    drive(1'b0, 127, 16'h4040, 1'b1, 1'b0, 16'h3F80, 4'b0010, 3);
    drive(1'b0, 127, 16'h40C0, 1'b1, 1'b0, 16'h3F82, 4'b0010, 3);
    drive(1'b0, 254, 16'hFFFF, 1'b1, 1'b0, 16'h7F80, 4'b1010, 4);
    drive(1'b1, 0,   16'h4000, 1'b1, 1'b0, 16'h8040, 4'b0000, 4);
    drive(1'b1, 5,   16'h0000, 1'b1, 1'b0, 16'h8000, 4'b0001, 1);
    drive(1'b0, -100, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'b0111, 3);
    drive(1'b0, 0,   16'h7FFF, 1'b1, 1'b0, 16'h0080, 4'b0010, 4);
    drive(1'b0, 127, 16'h7FC0, 1'b1, 1'b0, 16'h4000, 4'b0010, 3);
    drain();

    // Backpressure: result must hold while the consumer stalls
    bp_mode = 1'b1; bp_val = 1'b0;
    @(negedge clock);
    drive(1'b0, 127, 16'h40C0, 1'b1, 1'b0, 16'h3F82, 4'b0010, 3);
    for (int t = 0; t < 50 && !bus.out_valid; t++) @(negedge clock);
    r0 = bus.out_result;
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(negedge clock);
      check("bp_stable", 32'(bus.out_result), 32'(r0));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bp_val = 1'b1;
    drain();
    bp_mode = 1'b0;

    // Reset in NORM: operand discarded, nothing emitted afterwards
    drive(1'b0, -10, 16'h4000, 1'b0, 1'b0, 16'h0, 4'h0, 0);
    @(negedge clock);
    n_reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_result", 32'(bus.out_result), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (30) @(negedge clock);

    // Randomised operands against the reference model
    for (int n = 0; n < 300; n++) begin
      ce = $urandom_range(0, 4);
      case (ce)
        0: e = $urandom_range(110, 145);
        1: e = $urandom_range(0, 42) - 30;
        2: e = $urandom_range(240, 270);
        3: e = $urandom_range(0, 1023) - 512;
        default: e = $urandom_range(1, 20);
      endcase
      cm = $urandom_range(0, 9);
      m = 16'($urandom);
      case (cm)
        0: m = 16'h0000;
        1, 2: m = 16'($urandom_range(1, 255));
        3, 4: m = {m[15:7], 7'b1000000};
        5, 6: m = 16'h4000 | {2'b00, m[13:0]};
        default: ;
      endcase
      drive(1'($urandom), e, m, 1'b1, 1'b1, 16'h0, 4'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfloat16_packer.md
BFLOAT16_PACKER -- requirements
Module: bfloat16_packer

Interface
REQ-001 SHALL have parameter RSHIFT_CAP, default 24: maximum right-shift distance before the mantissa collapses to sticky.
REQ-002 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port n_reset, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: operand present.
REQ-005 SHALL have port in_ready, output, 1: block can accept; high only in IDLE.
REQ-006 SHALL have port in_sign, input, 1: result sign.
REQ-007 SHALL have port in_exponent, input, 10: signed two's-complement biased exponent, bias 127.
REQ-008 SHALL have port in_mantissa, input, 16: unsigned magnitude; value = (-1)^s x (m/2^14) x 2^(e-127); bit15 = carry, bit14 = hidden bit.
REQ-009 SHALL have port out_valid, output, 1: result present; held until accepted.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts.
REQ-011 SHALL have port out_result, output, 16: packed bfloat16 {sign, exp[7:0], frac[6:0]}.
REQ-012 SHALL have port out_flags, output, 4: {overflow, underflow, inexact, zero}.

Function
REQ-013 SHALL implement FSM IDLE -> NORM -> ROUND -> OUT -> IDLE.
REQ-014 IDLE: in_valid & in_ready captures sign, exponent, mantissa, sticky = 0; next state NORM.
REQ-015 Capture with in_mantissa == 0 SHALL skip to OUT with result {in_sign, 15'h0}, zero flag = 1.
REQ-016 Capture with exponent < 1-RSHIFT_CAP SHALL load mantissa 0, sticky = |in_mantissa, exponent 1.
REQ-017 NORM SHALL perform at most one shift per cycle, in priority order:
- m[15] = 1: shift right 1, exp+1, sticky |= shifted-out bit.
- exp < 1 and m != 0: shift right 1, exp+1, sticky |= shifted-out bit.
- m[14] = 0 and exp > 1: shift left 1, exp-1.
- otherwise: go to ROUND.
REQ-018 ROUND SHALL apply round-to-nearest-even with lsb = m[7], guard = m[6], sticky_all = sticky | (|m[5:0]); round up iff guard & (sticky_all | lsb).
REQ-019 Rounding increment on m[14:7] carrying to bit 15 SHALL give exp+1 and frac 0.
REQ-020 A subnormal rounding up into bit 14 SHALL encode exponent field 1.
REQ-021 m[14] = 0 after ROUND SHALL encode exponent field 0 (subnormal), frac = m[13:7].
REQ-022 Exponent >= 255 after ROUND SHALL give out_result {sign, 8'hFF, 7'h0}, overflow = 1, inexact = 1.
REQ-023 Flag rules:
- inexact = guard | sticky_all.
- underflow = inexact & result subnormal or zero.
- zero = result magnitude 0.
REQ-024 OUT: out_valid = 1 with out_result and out_flags stable; out_valid & out_ready -> IDLE next cycle.
REQ-025 Latency from the accept edge to out_valid SHALL be 3 + number of NORM shifts; the zero path is 1.
REQ-026 in_ready SHALL be 0 in NORM, ROUND and OUT; in_valid is ignored there.
REQ-027 Exponent arithmetic SHALL be 10-bit signed with no wrap; range -512..511.

Reset
REQ-028 n_reset low SHALL asynchronously force:
- state IDLE.
- out_valid 0, out_result 16'h0, out_flags 4'h0.
- in_ready 1 once released.
REQ-029 Reset mid-operation SHALL discard the operand with no partial result emitted.

Structure
REQ-030 bf16_pkg SHALL hold:
- the state enum.
- BF16_BIAS = 127, BF16_EXP_MAX = 255.
- flag bit index constants.
- the bf16_t packed struct.
REQ-031 Rounding SHALL be one combinational sub-module bf16_round_rne (m[14:0], exp, sticky -> result, flags).

Verification
REQ-032 Unity: exp=127, m=0x4000, s=0 -> 0x3F80, flags 0, out_valid 3 cycles after accept.
REQ-033 Carry: exp=127, m=0x8000 -> 0x4000, latency 4.
REQ-034 Round-to-even ties:
- m=0x4040 -> 0x3F80, inexact=1.
- m=0x40C0 -> 0x3F82, inexact=1.
REQ-035 Overflow: exp=254, m=0xFFFF -> 0x7F80, flags overflow=1, inexact=1.
REQ-036 Subnormal and zero:
- exp=0, m=0x4000, s=1 -> 0x8040, flags 0, latency 4.
- m=0, s=1 -> 0x8000, zero=1, latency 1.
REQ-037 Backpressure and reset:
- Hold out_ready=0 for 5 cycles -> out_result stable, in_ready 0.
- Assert n_reset in NORM -> out_valid 0, in_ready 1 after release.
